ja_pin_driver: RTL and testbench
================================

JA_PIN_DRIVER -- requirements
Module: ja_pin_driver

Interface
REQ-001 Parameter NUM_PINS, default 8, number of Pmod JA pins handled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, number of consecutive cycles a synchronized input must differ before it is accepted; legal range 2..65535.
REQ-003 Parameter PWM_WIDTH, default 8, width of the PWM counter and duty value.
REQ-004 s00_axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-005 s00_axi_aresetn  in  1  asynchronous, active-low reset.
REQ-006 reg_dir  in  NUM_PINS  per-pin direction from the register slave; 1=output, 0=input.
REQ-007 reg_out  in  NUM_PINS  static output level per pin.
REQ-008 reg_pwm_en  in  NUM_PINS  1 selects the PWM waveform instead of reg_out for that pin.
REQ-009 reg_pwm_duty  in  PWM_WIDTH  duty value shared by all PWM-enabled pins.
REQ-010 reg_irq_en  in  NUM_PINS  per-pin interrupt enable.
REQ-011 irq_clr  in  NUM_PINS  single-cycle write-1-to-clear pulse for edge_flags.
REQ-012 ja_i  in  NUM_PINS  raw asynchronous pad input.
REQ-013 ja_o  out  NUM_PINS  registered pad output value.
REQ-014 ja_t  out  NUM_PINS  registered tristate control; 1=high-Z (input), 0=driven.
REQ-015 pin_state  out  NUM_PINS  debounced input level, read back by the register slave.
REQ-016 edge_flags  out  NUM_PINS  sticky per-pin edge-detected flags.
REQ-017 irq  out  1  registered level interrupt.

Function
REQ-018 ja_i SHALL pass through a two-flop synchronizer per pin before any other use.
REQ-019 Per pin, a debounce counter SHALL increment each cycle the synchronized value differs from pin_state and clear to 0 on any cycle it equals pin_state.
REQ-020 When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, pin_state SHALL take the synchronized value and the counter SHALL clear on that same edge; total pad-to-pin_state latency is 2+DEBOUNCE_CYCLES cycles.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave pin_state unchanged.
REQ-022 An edge_flags bit SHALL set on the edge pin_state toggles (rising or falling) only if reg_dir for that pin is 0 at that edge.
REQ-023 An edge_flags bit SHALL clear on the edge after irq_clr for that bit is 1; simultaneous set and clear SHALL leave the bit set.
REQ-024 irq SHALL equal the registered OR of (edge_flags AND reg_irq_en), i.e. one cycle after the flag changes.
REQ-025 A free-running PWM counter SHALL count 0..2^PWM_WIDTH-2 and wrap to 0 (period 2^PWM_WIDTH-1 cycles).
REQ-026 PWM output SHALL be 1 when counter < reg_pwm_duty; duty 0 gives constant 0, duty 2^PWM_WIDTH-1 gives constant 1.
REQ-027 ja_o SHALL register (reg_pwm_en ? pwm : reg_out) per pin with one-cycle latency.
REQ-028 ja_t SHALL register NOT reg_dir with one-cycle latency; ja_o is computed regardless of direction.
REQ-029 Duty changes SHALL take effect on the next cycle's comparison without resetting the PWM counter.

Reset
REQ-030 While s00_axi_aresetn=0: ja_o=0, ja_t=all 1, pin_state=0, edge_flags=0, irq=0, synchronizers, debounce counters and PWM counter=0.
REQ-031 Reset asserted mid-debounce or mid-PWM period SHALL abort immediately; after release, debouncing restarts from pin_state=0.

Structure
REQ-032 Package ja_pin_pkg SHALL hold NUM_PINS/PWM_WIDTH defaults, the pin-vector typedef and the debounce counter width constant.
REQ-033 Per-pin synchronizer plus debounce SHALL be a sub-module ja_pin_debounce, instantiated NUM_PINS times via generate.

Verification (bench uses DEBOUNCE_CYCLES=4, PWM_WIDTH=8)
REQ-034 Reset release, no stimulus -> ja_t=0xFF, ja_o=0x00, irq=0.
REQ-035 reg_dir=0x00, reg_irq_en=0x01, ja_i[0] 0->1 held -> pin_state[0]=1 and edge_flags[0]=1 at cycle 6, irq=1 at cycle 7; irq_clr=0x01 -> irq=0 two cycles later.
REQ-036 ja_i[1] pulsed high for 3 cycles -> pin_state and edge_flags unchanged.
REQ-037 reg_dir=0xFF, reg_pwm_en=0x01, duty=64 -> ja_o[0] high 64 of every 255 cycles; duty=0 -> constant 0; duty=255 -> constant 1.
REQ-038 irq_clr=0x01 on the same edge edge_flags[0] sets -> flag stays 1; reg_dir[2]=1 while ja_i[2] toggles -> edge_flags[2] stays 0.
REQ-039 Assert reset with debounce counter at 2 and ja_o PWM high -> all outputs return to REQ-030 values asynchronously.

Source files
------------

// File: rtl/ja_pin_pkg.sv
// Shared constants and types for the Pmod JA pin driver.
// Parameters of the driver default to the values held here.
package ja_pin_pkg;

    localparam int NUM_PINS_DEF  = 8;
    localparam int PWM_WIDTH_DEF = 8;

    // Wide enough for the largest legal debounce length (65535).
    localparam int DB_CNT_W = 16;

    typedef logic [NUM_PINS_DEF-1:0] pin_vec_t;

endpackage

// File: rtl/ja_pin_driver_if.sv
// Register-slave side of the JA pin driver: control fields in, status/readback out.
interface ja_pin_driver_if
    import ja_pin_pkg::*;
#(
    parameter int NUM_PINS  = NUM_PINS_DEF,
    parameter int PWM_WIDTH = PWM_WIDTH_DEF
);
    logic [NUM_PINS-1:0]  reg_dir;
    logic [NUM_PINS-1:0]  reg_out;
    logic [NUM_PINS-1:0]  reg_pwm_en;
    logic [PWM_WIDTH-1:0] reg_pwm_duty;
    logic [NUM_PINS-1:0]  reg_irq_en;
    logic [NUM_PINS-1:0]  irq_clr;
    logic [NUM_PINS-1:0]  pin_state;
    logic [NUM_PINS-1:0]  edge_flags;
    logic                 irq;

    modport master (
        output reg_dir,
        output reg_out,
        output reg_pwm_en,
        output reg_pwm_duty,
        output reg_irq_en,
        output irq_clr,
        input  pin_state,
        input  edge_flags,
        input  irq
    );

    modport slave (
        input  reg_dir,
        input  reg_out,
        input  reg_pwm_en,
        input  reg_pwm_duty,
        input  reg_irq_en,
        input  irq_clr,
        output pin_state,
        output edge_flags,
        output irq
    );
endinterface

// File: rtl/ja_pin_debounce.sv
// One pad input: two-flop synchronizer followed by a consecutive-mismatch debouncer.
// 'toggle' pulses for the cycle whose edge updates pin_state.
module ja_pin_debounce
    import ja_pin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic s00_axi_aclk,
    input  logic s00_axi_aresetn,
    input  logic pin_raw,
    output logic pin_state,
    output logic toggle
);
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_reg;
    logic                sync2_reg;
    logic                state_reg;
    logic [DB_CNT_W-1:0] cnt_reg;
    logic                mismatch;
    logic                accept;

    assign mismatch = sync2_reg ^ state_reg;
    assign accept   = mismatch && (cnt_reg == CNT_LAST);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            state_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= pin_raw;
            sync2_reg <= sync1_reg;
            // Any agreeing cycle restarts the count, so only an unbroken run is accepted.
            if (!mismatch) begin
                cnt_reg <= '0;
            end else if (accept) begin
                cnt_reg   <= '0;
                state_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + DB_CNT_W'(1);
            end
        end
    end

    assign pin_state = state_reg;
    assign toggle    = accept;

endmodule

// File: rtl/ja_pin_driver.sv
// Pmod JA pin driver: per-pin debounced inputs with sticky edge flags and irq,
// plus registered static/PWM outputs and tristate control.
module ja_pin_driver
    import ja_pin_pkg::*;
#(
    parameter int NUM_PINS        = NUM_PINS_DEF,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int PWM_WIDTH       = PWM_WIDTH_DEF
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    ja_pin_driver_if.slave      regs,
    input  logic [NUM_PINS-1:0] ja_i,
    output logic [NUM_PINS-1:0] ja_o,
    output logic [NUM_PINS-1:0] ja_t
);
    // Counter stops one short of all-ones so a full-scale duty is a constant 1.
    localparam logic [PWM_WIDTH-1:0] PWM_LAST = {{(PWM_WIDTH-1){1'b1}}, 1'b0};

    logic [NUM_PINS-1:0]  state_vec;
    logic [NUM_PINS-1:0]  toggle_vec;
    logic [NUM_PINS-1:0]  edge_set;
    logic [NUM_PINS-1:0]  out_next;
    logic [NUM_PINS-1:0]  ja_o_reg;
    logic [NUM_PINS-1:0]  ja_t_reg;
    logic [NUM_PINS-1:0]  flags_reg;
    logic [NUM_PINS-1:0]  flags_next;
    logic                 irq_reg;
    logic [PWM_WIDTH-1:0] pwm_cnt_reg;
    logic                 pwm;

    generate
        for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            ja_pin_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .s00_axi_aclk   (s00_axi_aclk),
                .s00_axi_aresetn(s00_axi_aresetn),
                .pin_raw        (ja_i[gi]),
                .pin_state      (state_vec[gi]),
                .toggle         (toggle_vec[gi])
            );

            // Output pins never raise edge flags; direction is sampled on the toggle edge.
            assign edge_set[gi]   = toggle_vec[gi] & ~regs.reg_dir[gi];
            assign flags_next[gi] = (flags_reg[gi] & ~regs.irq_clr[gi]) | edge_set[gi];
            assign out_next[gi]   = regs.reg_pwm_en[gi] ? pwm : regs.reg_out[gi];
        end
    endgenerate

    assign pwm = (pwm_cnt_reg < regs.reg_pwm_duty);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pwm_cnt_reg <= '0;
        end else if (pwm_cnt_reg == PWM_LAST) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_WIDTH'(1);
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ja_o_reg  <= '0;
            ja_t_reg  <= '1;
            flags_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            ja_o_reg  <= out_next;
            ja_t_reg  <= ~regs.reg_dir;
            flags_reg <= flags_next;
            irq_reg   <= |(flags_reg & regs.reg_irq_en);
        end
    end

    assign ja_o            = ja_o_reg;
    assign ja_t            = ja_t_reg;
    assign regs.pin_state  = state_vec;
    assign regs.edge_flags = flags_reg;
    assign regs.irq        = irq_reg;

endmodule

// File: tb/tb_ja_pin_driver.sv
// Directed bench for ja_pin_driver with a cycle-level reference model and
// literal spot checks of debounce latency, flags, irq, PWM duty and reset.
`timescale 1ns/1ps
module tb_ja_pin_driver;
    import ja_pin_pkg::*;

    localparam int N   = 8;
    localparam int DB  = 4;
    localparam int PW  = 8;
    localparam int PER = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] ja_i;
    logic [N-1:0] ja_o;
    logic [N-1:0] ja_t;

    int errors = 0;
    int checks = 0;

    ja_pin_driver_if #(.NUM_PINS(N), .PWM_WIDTH(PW)) bus ();

    ja_pin_driver #(
        .NUM_PINS       (N),
        .DEBOUNCE_CYCLES(DB),
        .PWM_WIDTH      (PW)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .regs           (bus),
        .ja_i           (ja_i),
        .ja_o           (ja_o),
        .ja_t           (ja_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pin_state flips once the last DB synchronized samples all disagree with it;
    // the synchronized sample seen at an edge is the pad value captured two edges earlier.
    pin_vec_t    samp_q[$];
    pin_vec_t    used_q[$];
    pin_vec_t    m_state, m_flags, m_jao, m_jat;
    logic        m_irq;
    bit          m_started = 0;
    int unsigned m_edges;
    pin_vec_t    used, flip, nflags;
    bit          all_diff;
    logic        pwm_bit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q.delete();
            used_q.delete();
            m_state = '0; m_flags = '0; m_jao = '0; m_jat = '1; m_irq = 1'b0;
            m_edges = 0;
            m_started = 1;
        end else begin
            used = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : '0;
            samp_q.push_back(ja_i);
            used_q.push_back(used);
            if (used_q.size() > DB) void'(used_q.pop_front());
            flip = '0;
            for (int p = 0; p < N; p++) begin
                all_diff = (used_q.size() == DB);
                for (int j = 0; j < used_q.size(); j++)
                    if (used_q[j][p] == m_state[p]) all_diff = 0;
                flip[p] = all_diff;
            end
            nflags  = (m_flags & ~bus.irq_clr) | (flip & ~bus.reg_dir);
            m_irq   = |(m_flags & bus.reg_irq_en);
            pwm_bit = ((m_edges % PER) < bus.reg_pwm_duty);
            for (int p = 0; p < N; p++)
                m_jao[p] = bus.reg_pwm_en[p] ? pwm_bit : bus.reg_out[p];
            m_jat   = ~bus.reg_dir;
            m_state = m_state ^ flip;
            m_flags = nflags;
            m_edges++;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("model_ja_o", 32'(ja_o), 32'(m_jao));
            check("model_ja_t", 32'(ja_t), 32'(m_jat));
            check("model_pin_state", 32'(bus.pin_state), 32'(m_state));
            check("model_edge_flags", 32'(bus.edge_flags), 32'(m_flags));
            check("model_irq", 32'(bus.irq), 32'(m_irq));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic count_high(input string name, input int exp);
        int hi = 0;
        for (int k = 0; k < PER; k++) begin
            tick();
            hi += int'(ja_o[0]);
        end
        $display("PWM %s: ja_o[0] high %0d of %0d cycles", name, hi, PER);
        check(name, 32'(hi), 32'(exp));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        ja_i = '0;
        bus.reg_dir = '0; bus.reg_out = '0; bus.reg_pwm_en = '0;
        bus.reg_pwm_duty = '0; bus.reg_irq_en = '0; bus.irq_clr = '0;

        repeat (3) tick();
        check("reset_ja_t", 32'(ja_t), 32'h0000_00FF);
        check("reset_ja_o", 32'(ja_o), 32'h0);
        check("reset_pin_state", 32'(bus.pin_state), 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_ja_t", 32'(ja_t), 32'h0000_00FF);
        check("idle_ja_o", 32'(ja_o), 32'h0);
        check("idle_irq", 32'(bus.irq), 32'h0);
        $display("TXN reset release: ja_t=%h ja_o=%h irq=%b", ja_t, ja_o, bus.irq);

        // pin 0 rising edge, irq enabled
        bus.reg_irq_en = 8'h01;
        ja_i[0] = 1'b1;
        repeat (5) tick();
        check("db_pin0_cycle5", 32'(bus.pin_state[0]), 32'h0);
        tick();
        check("db_pin0_cycle6", 32'(bus.pin_state[0]), 32'h1);
        check("flag0_cycle6", 32'(bus.edge_flags[0]), 32'h1);
        check("irq_cycle6", 32'(bus.irq), 32'h0);
        tick();
        check("irq_cycle7", 32'(bus.irq), 32'h1);
        bus.irq_clr = 8'h01;
        tick();
        bus.irq_clr = 8'h00;
        check("flag0_cleared", 32'(bus.edge_flags[0]), 32'h0);
        check("irq_still_set", 32'(bus.irq), 32'h1);
        tick();
        check("irq_cleared", 32'(bus.irq), 32'h0);
        $display("TXN pin0 rise: pin_state=%h flags=%h irq=%b", bus.pin_state, bus.edge_flags, bus.irq);

        // pin 1 glitch of 3 cycles
        ja_i[1] = 1'b1;
        repeat (3) tick();
        ja_i[1] = 1'b0;
        repeat (8) tick();
        check("glitch_pin_state", 32'(bus.pin_state), 32'h01);
        check("glitch_flags", 32'(bus.edge_flags), 32'h00);
        $display("TXN pin1 glitch: pin_state=%h flags=%h", bus.pin_state, bus.edge_flags);

        // pin 0 falling edge coinciding with irq_clr: set wins
        ja_i[0] = 1'b0;
        repeat (5) tick();
        bus.irq_clr = 8'h01;
        tick();
        bus.irq_clr = 8'h00;
        check("setclr_pin_state", 32'(bus.pin_state[0]), 32'h0);
        check("setclr_flag0", 32'(bus.edge_flags[0]), 32'h1);
        tick();
        check("setclr_irq", 32'(bus.irq), 32'h1);
        $display("TXN pin0 fall + clr: flags=%h irq=%b", bus.edge_flags, bus.irq);

        // pin 2 toggles while configured as output: no flag
        bus.reg_dir = 8'h04;
        ja_i[2] = 1'b1;
        repeat (7) tick();
        check("outpin_state", 32'(bus.pin_state[2]), 32'h1);
        check("outpin_flag2", 32'(bus.edge_flags[2]), 32'h0);
        check("outpin_ja_t", 32'(ja_t), 32'h0000_00FB);
        $display("TXN pin2 as output: pin_state=%h flags=%h ja_t=%h", bus.pin_state, bus.edge_flags, ja_t);

        // PWM on pin 0, static levels elsewhere
        bus.reg_dir = 8'hFF;
        bus.reg_pwm_en = 8'h01;
        bus.reg_out = 8'hA0;
        bus.reg_pwm_duty = 8'd64;
        repeat (2) tick();
        check("static_ja_o", 32'(ja_o[7:1]), 32'h50);
        check("all_out_ja_t", 32'(ja_t), 32'h0);
        count_high("pwm_duty64", 64);
        bus.reg_pwm_duty = 8'd0;
        repeat (2) tick();
        count_high("pwm_duty0", 0);
        bus.reg_pwm_duty = 8'd255;
        repeat (2) tick();
        count_high("pwm_duty255", 255);

        // asynchronous reset mid-debounce (pin 3 counter at 2) with PWM output high
        ja_i[3] = 1'b1;
        repeat (4) tick();
        check("pre_reset_ja_o0", 32'(ja_o[0]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_ja_o", 32'(ja_o), 32'h0);
        check("async_ja_t", 32'(ja_t), 32'h0000_00FF);
        check("async_pin_state", 32'(bus.pin_state), 32'h0);
        check("async_flags", 32'(bus.edge_flags), 32'h0);
        check("async_irq", 32'(bus.irq), 32'h0);
        $display("TXN async reset: ja_o=%h ja_t=%h pin_state=%h flags=%h irq=%b",
                 ja_o, ja_t, bus.pin_state, bus.edge_flags, bus.irq);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("restart_cycle5", 32'(bus.pin_state), 32'h00);
        tick();
        check("restart_cycle6", 32'(bus.pin_state), 32'h0C);
        check("restart_flags", 32'(bus.edge_flags), 32'h00);
        $display("TXN debounce restart: pin_state=%h", bus.pin_state);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
